// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer in front of the UART core: circular FIFO on the write
// side, a small FSM that hands bytes to the UART one at a time on the read side.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2   = 4,
  parameter int RETRY_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  clear_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  input  logic                  is_transmitting,
  output logic [1:0]            state_o
);

  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
  localparam logic [3:0]    RETRY_ONE = 4'd1;
  localparam logic [3:0]    RETRY_LIM = 4'(RETRY_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [3:0]    retry_q, retry_d;
  state_e        state_q, state_d;

  logic push;
  logic drop;
  logic pop;

  // Flush clears the queue only; a write in the flush cycle is discarded
  // silently and never counts as an overflow.
  always_comb begin
    push       = wr_en && !full_q && !flush;
    drop       = wr_en && full_q && !flush;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == FULL_LVL);
    empty_d = (count_d == '0);
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
    tx_byte_d = pop ? mem_q[rd_ptr_q] : tx_byte_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
    end
  end

  // UART handshake: transmit is a one-cycle request; the UART acknowledges by
  // raising is_transmitting and frees the line by dropping it. A request with
  // no rise within RETRY_CYCLES is re-issued with the same byte.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q && !is_transmitting) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        retry_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (is_transmitting) begin
          state_d = S_WAIT_DONE;
        end else begin
          retry_d = retry_q + RETRY_ONE;
          if (retry_d == RETRY_LIM) state_d = S_START;
        end
      end
      S_WAIT_DONE: begin
        if (!is_transmitting) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    transmit = (state_q == S_START);
    busy     = (state_q != S_IDLE) || !empty_q;
    state_o  = state_q;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_byte  = tx_byte_q;

endmodule
